ps2_key_tracker: RTL

- Consumes the byte stream from the PS/2 receiver: one strobe per received scan-code byte.
- Decodes make, break (F0) and extended (E0) prefixes into single key events.
- Tracks modifier state (shift, ctrl, alt, caps lock), suppresses typematic repeats using a held-key table, counts key presses, and keeps a short history of recent key codes.
- Its outputs feed the seven-segment and LED display logic.

---
 rtl/ps2_key_tracker_if.sv | 23 ++
 rtl/ps2_key_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker_if.sv
// Byte-stream and key-event bundle of the PS/2 key tracker.
//   code_valid/code : one strobe per received scan-code byte (source -> tracker)
//   evt_*           : completed key event, evt_valid pulses for one cycle (tracker -> sink)
// master = byte source / event consumer, slave = the tracker.
interface ps2_key_tracker_if;
    logic       code_valid;
    logic [7:0] code;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;

    modport master (
        output code_valid, code,
        input  evt_valid, evt_code, evt_ext, evt_break, evt_repeat
    );

    modport slave (
        input  code_valid, code,
        output evt_valid, evt_code, evt_ext, evt_break, evt_repeat
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: folds E0/F0 prefixes into single key events, keeps modifier
// state, a held-key table (typematic repeat detection), a press counter and a
// short history of recent non-modifier key codes.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   bus           : byte input and key event output (slave modport)
//   mods          : {caps, alt, ctrl, shift}
//   press_cnt     : counted key presses
//   held_cnt      : occupied held-table entries
//   held_overflow : a press was dropped because the table was full
//   any_held      : held_cnt != 0
//   hist          : recent key codes, [7:0] newest
module ps2_key_tracker #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned HIST_DEPTH   = 3,
    parameter int unsigned MAX_HELD     = 4,
    parameter bit          COUNT_REPEAT = 1'b0,
    parameter bit          SAT_CNT      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_tracker_if.slave        bus,
    output logic [3:0]              mods,
    output logic [CNT_W-1:0]        press_cnt,
    output logic [3:0]              held_cnt,
    output logic                    held_overflow,
    output logic                    any_held,
    output logic [8*HIST_DEPTH-1:0] hist
);
    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    // Key identity is {ext, code}.
    localparam logic [8:0] KLShift = 9'h012;
    localparam logic [8:0] KRShift = 9'h059;
    localparam logic [8:0] KLCtrl  = 9'h014;
    localparam logic [8:0] KRCtrl  = 9'h114;
    localparam logic [8:0] KLAlt   = 9'h011;
    localparam logic [8:0] KRAlt   = 9'h111;
    localparam logic [8:0] KCaps   = 9'h058;

    state_e state_q, state_d;
    logic   done, cur_ext, cur_brk, is_proto;
    logic [8:0] key;

    logic [MAX_HELD-1:0] held_vld_q, held_vld_d, hit_vec, free_oh;
    logic [8:0]          held_key_q [MAX_HELD];
    logic [8:0]          held_key_d [MAX_HELD];
    logic                hit, full, free_found;

    logic [5:0] modb_q, modb_d, mod_sel; // {ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic       caps_q, caps_d, is_caps;
    logic       make_new, counted;

    assign is_proto = (bus.code == 8'h00) || (bus.code == 8'hAA) || (bus.code == 8'hE1) ||
                      (bus.code == 8'hFA) || (bus.code == 8'hFE) || (bus.code == 8'hFF);

    // Prefix FSM; only protocol bytes and completed events return to idle.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        cur_ext = 1'b0;
        cur_brk = 1'b0;
        if (bus.code_valid) begin
            if (is_proto) begin
                state_d = StIdle;
            end else if (bus.code == 8'hF0) begin
                unique case (state_q)
                    StIdle:  state_d = StBrk;
                    StExt:   state_d = StExtBrk;
                    default: state_d = state_q;
                endcase
            end else if (bus.code == 8'hE0) begin
                // E0 after F0 is not a legal sequence; keep the pending break.
                if (state_q == StIdle) state_d = StExt;
            end else begin
                done    = 1'b1;
                state_d = StIdle;
                cur_ext = (state_q == StExt) || (state_q == StExtBrk);
                cur_brk = (state_q == StBrk) || (state_q == StExtBrk);
            end
        end
    end

    assign key = {cur_ext, bus.code};

    // Table lookup: matching entry and lowest free slot.
    always_comb begin
        hit_vec    = '0;
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(MAX_HELD); i++) begin
            hit_vec[i] = held_vld_q[i] && (held_key_q[i] == key);
            if (!held_vld_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    assign hit  = |hit_vec;
    assign full = &held_vld_q;

    always_comb begin
        mod_sel = '0;
        case (key)
            KLShift: mod_sel[0] = 1'b1;
            KRShift: mod_sel[1] = 1'b1;
            KLCtrl:  mod_sel[2] = 1'b1;
            KRCtrl:  mod_sel[3] = 1'b1;
            KLAlt:   mod_sel[4] = 1'b1;
            KRAlt:   mod_sel[5] = 1'b1;
            default: mod_sel    = '0;
        endcase
    end

    assign is_caps  = (key == KCaps);
    assign make_new = done && !cur_brk && !hit;
    assign counted  = done && !cur_brk && (!hit || COUNT_REPEAT);

    always_comb begin
        held_vld_d = held_vld_q;
        held_key_d = held_key_q;
        modb_d     = modb_q;
        caps_d     = caps_q;
        if (done) begin
            if (cur_brk) begin
                held_vld_d = held_vld_q & ~hit_vec;
                modb_d     = modb_q & ~mod_sel;
            end else begin
                modb_d = modb_q | mod_sel;
                if (!hit) begin
                    held_vld_d = held_vld_q | free_oh;
                    for (int i = 0; i < int'(MAX_HELD); i++) begin
                        if (free_oh[i]) held_key_d[i] = key;
                    end
                    if (is_caps) caps_d = ~caps_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            held_vld_q     <= '0;
            for (int i = 0; i < int'(MAX_HELD); i++) held_key_q[i] <= '0;
            modb_q         <= '0;
            caps_q         <= 1'b0;
            press_cnt      <= '0;
            held_cnt       <= '0;
            held_overflow  <= 1'b0;
            hist           <= '0;
            bus.evt_valid  <= 1'b0;
            bus.evt_code   <= '0;
            bus.evt_ext    <= 1'b0;
            bus.evt_break  <= 1'b0;
            bus.evt_repeat <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_vld_q    <= held_vld_d;
            held_key_q    <= held_key_d;
            modb_q        <= modb_d;
            caps_q        <= caps_d;
            bus.evt_valid <= done;
            if (done) begin
                bus.evt_code   <= bus.code;
                bus.evt_ext    <= cur_ext;
                bus.evt_break  <= cur_brk;
                bus.evt_repeat <= !cur_brk && hit;
            end
            if (counted && !(SAT_CNT && (&press_cnt))) press_cnt <= press_cnt + 1'b1;
            if (make_new && !full) begin
                held_cnt <= held_cnt + 4'd1;
            end else if (done && cur_brk && hit) begin
                held_cnt <= held_cnt - 4'd1;
                if (held_cnt == 4'd1) held_overflow <= 1'b0;
            end
            if (make_new && full) held_overflow <= 1'b1;
            if (make_new && !is_caps && (mod_sel == '0)) begin
                hist       <= hist << 8;
                hist[7:0]  <= bus.code;
            end
        end
    end

    assign mods     = {caps_q, modb_q[5] | modb_q[4], modb_q[3] | modb_q[2],
                       modb_q[1] | modb_q[0]};
    assign any_held = (held_cnt != 4'd0);
endmodule
